hypipe_pkt_meta_merge: RTL and testbench

Parametrised packet/metadata merge stage of the hybrid packet processing pipeline. Buffers packet beats from the PHV generator, waits for the per-packet metadata produced later by the parser/deparser, and emits each admitted packet with its metadata under a downstream ready handshake. An optional MAC rewrite is applied to the head beat. Admission control drops whole packets when buffer space is short.

---
 rtl/hypipe_pkt_meta_merge_pkg.sv | 28 ++
 rtl/hypipe_pkt_meta_merge_if.sv | 25 ++
 rtl/hypipe_pkt_meta_merge_sync_fifo.sv | 59 +++++
 rtl/hypipe_pkt_meta_merge.sv | 214 +++++++++++++++++++++
 tb/tb_hypipe_pkt_meta_merge.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hypipe_pkt_meta_merge_pkg.sv
// Shared constants and types for the packet/metadata merge stage:
// beat tag encodings, rewrite modes and the output FSM state type.
package hypipe_pkg;

   localparam logic [1:0] TAG_BODY   = 2'b00;
   localparam logic [1:0] TAG_HEAD   = 2'b01;
   localparam logic [1:0] TAG_TAIL   = 2'b10;
   localparam logic [1:0] TAG_SINGLE = 2'b11;

   localparam int MODE_PASS    = 0;
   localparam int MODE_DST     = 1;
   localparam int MODE_DST_SRC = 2;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

   // HEAD and SINGLE both open a packet; TAIL and SINGLE both close one.
   function automatic logic tag_is_head(input logic [1:0] tag);
      return tag[0];
   endfunction

   function automatic logic tag_is_tail(input logic [1:0] tag);
      return tag[1];
   endfunction

endpackage

// File: rtl/hypipe_pkt_meta_merge_if.sv
// Beat/metadata bus of the merge stage; the design sits on the slave side.
interface hypipe_pkt_meta_merge_if #(
   parameter int DATA_W = 128,
   parameter int VLD_W  = $clog2(DATA_W/8),
   parameter int META_W = 128
);
   logic                       i_data_valid;
   logic [DATA_W+VLD_W+1:0]    i_data;
   logic                       i_meta_valid;
   logic [META_W-1:0]          i_meta;
   logic                       o_data_valid;
   logic [DATA_W+VLD_W+1:0]    o_data;
   logic [META_W-1:0]          o_meta;
   logic                       i_ready;

   modport slave (
      input  i_data_valid, i_data, i_meta_valid, i_meta, i_ready,
      output o_data_valid, o_data, o_meta
   );

   modport master (
      output i_data_valid, i_data, i_meta_valid, i_meta, i_ready,
      input  o_data_valid, o_data, o_meta
   );
endinterface

// File: rtl/hypipe_pkt_meta_merge_sync_fifo.sv
// Single-clock show-ahead FIFO; a push into a full FIFO is honoured when a
// pop happens in the same cycle.
module hypipe_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             wr_en_s;
   logic             rd_en_s;

   assign rd_en_s = pop_i & ~empty_o;
   assign wr_en_s = push_i & (~full_o | rd_en_s);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == (AW+1)'(0));
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // Storage array carries no reset; only pointers define the contents.
   always_ff @(posedge clk_i) begin
      if (wr_en_s) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en_s) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (rd_en_s) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({wr_en_s, rd_en_s})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end
endmodule

// File: rtl/hypipe_pkt_meta_merge.sv
// Packet/metadata merge stage: admits or drops whole packets at the head,
// pairs buffered beats with late-arriving metadata, optional MAC rewrite.
module hypipe_pkt_meta_merge
   import hypipe_pkg::*;
#(
   parameter int DATA_W        = 128,
   parameter int VLD_W         = $clog2(DATA_W/8),
   parameter int META_W        = 128,
   parameter int PKT_DEPTH     = 512,
   parameter int META_DEPTH    = 16,
   parameter int FLAG_DEPTH    = 32,
   parameter int MAX_PKT_BEATS = 128,
   parameter int MODE          = 0
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   hypipe_pkt_meta_merge_if.slave       bus,
   output logic [31:0]                  o_drop_cnt,
   output logic                         o_err
);
   localparam int BEAT_W = DATA_W + VLD_W + 2;
   localparam int PKT_CW = $clog2(PKT_DEPTH) + 1;

   logic                  in_vld_q;
   logic [BEAT_W-1:0]     in_beat_q;
   logic                  meta_vld_q;
   logic [META_W-1:0]     meta_in_q;
   logic                  active_q, active_d;
   logic                  admit_q, admit_d;
   logic [31:0]           drop_cnt_q;
   logic                  err_q;
   state_e                state_q, state_d;
   logic                  out_vld_q, out_vld_d;
   logic [BEAT_W-1:0]     out_data_q, out_data_d;
   logic [META_W-1:0]     out_meta_q, out_meta_d;

   logic [1:0]            in_tag_s;
   logic [PKT_CW-1:0]     free_s;
   logic                  admit_s;
   logic                  pkt_want_s, pkt_push_s, pkt_pop_s, pkt_full_s, pkt_empty_s, pkt_ovf_s;
   logic [BEAT_W-1:0]     pkt_rdata_s;
   logic [PKT_CW-1:0]     pkt_count_s;
   logic                  flag_push_s, flag_push_ok_s, flag_pop_s, flag_full_s, flag_empty_s;
   logic                  flag_rdata_s, flag_ovf_s, orphan_s;
   logic [$clog2(FLAG_DEPTH):0] flag_count_s;
   logic                  meta_want_s, meta_push_s, meta_pop_s, meta_full_s, meta_empty_s, meta_ovf_s;
   logic [META_W-1:0]     meta_rdata_s;
   logic [$clog2(META_DEPTH):0] meta_count_s;
   logic                  drop_inc_s;
   logic                  unused_s;

   function automatic logic [BEAT_W-1:0] rewrite_head(input logic [BEAT_W-1:0] beat,
                                                      input logic [META_W-1:0] meta);
      logic [BEAT_W-1:0] r;
      r = beat;
      if (MODE == MODE_DST || MODE == MODE_DST_SRC) begin
         r[DATA_W-1 -: 48] = meta[47:0];
      end else begin
         r = beat;
      end
      if (MODE == MODE_DST_SRC) begin
         r[DATA_W-49 -: 48] = meta[95:48];
      end else begin
         r = r;
      end
      return r;
   endfunction

   // Input stage: one register between the bus and the FIFO write ports.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         in_vld_q   <= 1'b0;
         in_beat_q  <= '0;
         meta_vld_q <= 1'b0;
         meta_in_q  <= '0;
      end else begin
         in_vld_q   <= bus.i_data_valid;
         in_beat_q  <= bus.i_data;
         meta_vld_q <= bus.i_meta_valid;
         meta_in_q  <= bus.i_meta;
      end
   end

   assign in_tag_s = in_beat_q[BEAT_W-1 -: 2];
   assign free_s   = PKT_CW'(PKT_DEPTH) - pkt_count_s + {{(PKT_CW-1){1'b0}}, pkt_pop_s};
   assign admit_s  = (free_s >= PKT_CW'(MAX_PKT_BEATS));

   // Admission: decide at the head, then follow that decision to the tail.
   always_comb begin
      pkt_want_s  = 1'b0;
      flag_push_s = 1'b0;
      drop_inc_s  = 1'b0;
      active_d    = active_q;
      admit_d     = admit_q;
      if (in_vld_q && tag_is_head(in_tag_s)) begin
         flag_push_s = 1'b1;
         pkt_want_s  = admit_s;
         drop_inc_s  = ~admit_s;
         active_d    = ~tag_is_tail(in_tag_s);
         admit_d     = admit_s;
      end else if (in_vld_q && active_q) begin
         pkt_want_s  = admit_q;
         active_d    = ~tag_is_tail(in_tag_s);
      end else begin
         pkt_want_s  = 1'b0;
      end
   end

   assign pkt_push_s     = pkt_want_s & (~pkt_full_s | pkt_pop_s);
   assign pkt_ovf_s      = pkt_want_s & ~pkt_push_s;
   assign flag_pop_s     = meta_vld_q & ~flag_empty_s;
   assign orphan_s       = meta_vld_q & flag_empty_s;
   assign flag_push_ok_s = flag_push_s & (~flag_full_s | flag_pop_s);
   assign flag_ovf_s     = flag_push_s & ~flag_push_ok_s;
   assign meta_want_s    = flag_pop_s & flag_rdata_s;
   assign meta_push_s    = meta_want_s & (~meta_full_s | meta_pop_s);
   assign meta_ovf_s     = meta_want_s & ~meta_push_s;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         active_q   <= 1'b0;
         admit_q    <= 1'b0;
         drop_cnt_q <= 32'd0;
         err_q      <= 1'b0;
      end else begin
         active_q   <= active_d;
         admit_q    <= admit_d;
         drop_cnt_q <= drop_inc_s ? drop_cnt_q + 32'd1 : drop_cnt_q;
         err_q      <= err_q | pkt_ovf_s | flag_ovf_s | orphan_s | meta_ovf_s;
      end
   end

   hypipe_sync_fifo #(.WIDTH(BEAT_W), .DEPTH(PKT_DEPTH)) u_pkt_fifo (
      .clk_i(i_clk), .rst_ni(i_rst_n),
      .push_i(pkt_push_s), .wdata_i(in_beat_q), .pop_i(pkt_pop_s),
      .rdata_o(pkt_rdata_s), .count_o(pkt_count_s), .full_o(pkt_full_s), .empty_o(pkt_empty_s)
   );

   hypipe_sync_fifo #(.WIDTH(1), .DEPTH(FLAG_DEPTH)) u_flag_fifo (
      .clk_i(i_clk), .rst_ni(i_rst_n),
      .push_i(flag_push_ok_s), .wdata_i(admit_s), .pop_i(flag_pop_s),
      .rdata_o(flag_rdata_s), .count_o(flag_count_s), .full_o(flag_full_s), .empty_o(flag_empty_s)
   );

   hypipe_sync_fifo #(.WIDTH(META_W), .DEPTH(META_DEPTH)) u_meta_fifo (
      .clk_i(i_clk), .rst_ni(i_rst_n),
      .push_i(meta_push_s), .wdata_i(meta_in_q), .pop_i(meta_pop_s),
      .rdata_o(meta_rdata_s), .count_o(meta_count_s), .full_o(meta_full_s), .empty_o(meta_empty_s)
   );

   assign unused_s = ^{flag_count_s, meta_count_s};

   // Output FSM: IDLE loads the (rewritten) head, SEND streams to the tail.
   always_comb begin
      state_d    = state_q;
      out_vld_d  = out_vld_q;
      out_data_d = out_data_q;
      out_meta_d = out_meta_q;
      pkt_pop_s  = 1'b0;
      meta_pop_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!meta_empty_s && !pkt_empty_s) begin
               pkt_pop_s  = 1'b1;
               out_data_d = rewrite_head(pkt_rdata_s, meta_rdata_s);
               out_meta_d = meta_rdata_s;
               out_vld_d  = 1'b1;
               state_d    = ST_SEND;
            end else begin
               out_vld_d  = 1'b0;
            end
         end
         ST_SEND: begin
            if (out_vld_q && bus.i_ready && tag_is_tail(out_data_q[BEAT_W-1 -: 2])) begin
               meta_pop_s = 1'b1;
               out_vld_d  = 1'b0;
               state_d    = ST_IDLE;
            end else if ((!out_vld_q || bus.i_ready) && !pkt_empty_s) begin
               pkt_pop_s  = 1'b1;
               out_data_d = pkt_rdata_s;
               out_vld_d  = 1'b1;
            end else if (bus.i_ready) begin
               out_vld_d  = 1'b0;
            end else begin
               out_vld_d  = out_vld_q;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            out_vld_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_IDLE;
         out_vld_q  <= 1'b0;
         out_data_q <= '0;
         out_meta_q <= '0;
      end else begin
         state_q    <= state_d;
         out_vld_q  <= out_vld_d;
         out_data_q <= out_data_d;
         out_meta_q <= out_meta_d;
      end
   end

   assign bus.o_data_valid = out_vld_q;
   assign bus.o_data       = out_data_q;
   assign bus.o_meta       = out_meta_q;
   assign o_drop_cnt       = drop_cnt_q;
   assign o_err            = err_q;
endmodule

// File: tb/tb_hypipe_pkt_meta_merge.sv
// Scoreboard bench for hypipe_pkt_meta_merge: a MODE 0 instance carries most
// scenarios, a MODE 2 instance covers the MAC rewrite.
module tb_hypipe_pkt_meta_merge;
   import hypipe_pkg::*;

   localparam int DATA_W = 128;
   localparam int VLD_W  = 4;
   localparam int META_W = 128;
   localparam int BEAT_W = DATA_W + VLD_W + 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hypipe_pkt_meta_merge_if #(.DATA_W(DATA_W), .VLD_W(VLD_W), .META_W(META_W)) bus0 ();
   hypipe_pkt_meta_merge_if #(.DATA_W(DATA_W), .VLD_W(VLD_W), .META_W(META_W)) bus2 ();
   logic [31:0] drop0, drop2;
   logic        err0, err2;

   hypipe_pkt_meta_merge #(.DATA_W(DATA_W), .VLD_W(VLD_W), .META_W(META_W), .PKT_DEPTH(16),
      .META_DEPTH(4), .FLAG_DEPTH(4), .MAX_PKT_BEATS(8), .MODE(0)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus0), .o_drop_cnt(drop0), .o_err(err0));

   hypipe_pkt_meta_merge #(.DATA_W(DATA_W), .VLD_W(VLD_W), .META_W(META_W), .PKT_DEPTH(16),
      .META_DEPTH(4), .FLAG_DEPTH(4), .MAX_PKT_BEATS(8), .MODE(2)) dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus2), .o_drop_cnt(drop2), .o_err(err2));

   typedef struct {
      logic [BEAT_W-1:0] beat;
      logic [META_W-1:0] meta;
      bit                head;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;

   // Scoreboard monitor for dut0: front entry must be on the bus while valid,
   // popped only when the beat is accepted.
   always @(negedge clk) begin
      if (mon_en && rst_n && bus0.o_data_valid) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got %h, expected no beat", bus0.o_data);
         end else begin
            if (bus0.o_data !== sb[0].beat) begin
               errors++;
               $display("FAIL beat_data: got %h, expected %h", bus0.o_data, sb[0].beat);
            end
            if (sb[0].head) begin
               checks++;
               if (bus0.o_meta !== sb[0].meta) begin
                  errors++;
                  $display("FAIL head_meta: got %h, expected %h", bus0.o_meta, sb[0].meta);
               end
            end
            if (bus0.i_ready) void'(sb.pop_front());
         end
      end
   end

   function automatic logic [DATA_W-1:0] rand_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_beat(input bit to2, input logic [1:0] tag, input logic [VLD_W-1:0] vc,
                             input logic [DATA_W-1:0] d);
      if (to2) begin
         bus2.i_data_valid = 1'b1;
         bus2.i_data       = {tag, vc, d};
      end else begin
         bus0.i_data_valid = 1'b1;
         bus0.i_data       = {tag, vc, d};
      end
      tick();
      bus0.i_data_valid = 1'b0;
      bus2.i_data_valid = 1'b0;
   endtask

   task automatic drive_meta(input bit to2, input logic [META_W-1:0] m);
      if (to2) begin
         bus2.i_meta_valid = 1'b1;
         bus2.i_meta       = m;
      end else begin
         bus0.i_meta_valid = 1'b1;
         bus0.i_meta       = m;
      end
      tick();
      bus0.i_meta_valid = 1'b0;
      bus2.i_meta_valid = 1'b0;
   endtask

   task automatic send_pkt(input int nbeats, input logic [META_W-1:0] m, input bit expect_out);
      exp_t e;
      logic [1:0] tag;
      logic [VLD_W-1:0] vc;
      logic [DATA_W-1:0] d;
      for (int i = 0; i < nbeats; i++) begin
         if (nbeats == 1)          tag = TAG_SINGLE;
         else if (i == 0)          tag = TAG_HEAD;
         else if (i == nbeats - 1) tag = TAG_TAIL;
         else                      tag = TAG_BODY;
         vc = VLD_W'($urandom);
         d  = rand_data();
         if (expect_out) begin
            e.beat = {tag, vc, d};
            e.meta = m;
            e.head = (i == 0);
            sb.push_back(e);
         end
         drive_beat(1'b0, tag, vc, d);
      end
   endtask

   task automatic wait_drain(input int max_cycles, input string name);
      for (int i = 0; i < max_cycles && sb.size() != 0; i++) tick();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d beats still pending, expected 0", name, sb.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus0.o_data_valid, bus0.o_data, bus0.o_meta, drop0, err0} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got vld=%b data=%h meta=%h drop=%0d err=%b, expected all 0",
                  bus0.o_data_valid, bus0.o_data, bus0.o_meta, drop0, err0);
      end
      checks++;
      if ({bus2.o_data_valid, bus2.o_data, drop2, err2} !== '0) begin
         errors++;
         $display("FAIL reset_outputs_mode2: got vld=%b data=%h, expected 0", bus2.o_data_valid, bus2.o_data);
      end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_mode0_latency();
      logic [META_W-1:0] m;
      logic [2:0] seen;
      m = {$urandom, $urandom, $urandom, $urandom};
      send_pkt(4, m, 1'b1);
      repeat (3) tick();
      drive_meta(1'b0, m);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         seen[i] = bus0.o_data_valid;
      end
      checks++;
      if (seen !== 3'b100) begin
         errors++;
         $display("FAIL head_latency: valid after meta edge +0/+1/+2 = %b, expected 100", seen);
      end
      tick();
      wait_drain(10, "mode0");
   endtask

   task automatic test_mode2_rewrite();
      logic [DATA_W-1:0] d;
      logic [VLD_W-1:0]  vc;
      logic [META_W-1:0] m;
      logic [BEAT_W-1:0] exp_beat;
      int n;
      d  = rand_data();
      vc = 4'd9;
      m  = {32'h0, 48'hAABBCCDDEEFF, 48'h112233445566};
      exp_beat = {TAG_SINGLE, vc, 48'h112233445566, 48'hAABBCCDDEEFF, d[31:0]};
      drive_beat(1'b1, TAG_SINGLE, vc, d);
      drive_meta(1'b1, m);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus2.o_data_valid && n < 20);
      checks++;
      if (!bus2.o_data_valid) begin
         errors++;
         $display("FAIL mode2_timeout: no beat within 20 cycles, expected one");
      end else begin
         checks++;
         if (bus2.o_data !== exp_beat) begin
            errors++;
            $display("FAIL mode2_rewrite: got %h, expected %h", bus2.o_data, exp_beat);
         end
         checks++;
         if (bus2.o_meta !== m) begin
            errors++;
            $display("FAIL mode2_meta: got %h, expected %h", bus2.o_meta, m);
         end
      end
      @(negedge clk);
      checks++;
      if (bus2.o_data_valid !== 1'b0 || err2 !== 1'b0 || drop2 !== 32'd0) begin
         errors++;
         $display("FAIL mode2_after: got vld=%b err=%b drop=%0d, expected 0/0/0",
                  bus2.o_data_valid, err2, drop2);
      end
      tick();
   endtask

   task automatic test_drop_back_to_back();
      logic [META_W-1:0] ma, mb, mc;
      logic [12:0] pat;
      int n;
      ma = {4{$urandom}};
      mb = {4{$urandom}};
      mc = {4{$urandom}};
      send_pkt(6, ma, 1'b1);
      send_pkt(6, mb, 1'b1);
      send_pkt(6, mc, 1'b0);
      repeat (3) tick();
      checks++;
      if (drop0 !== 32'd1) begin
         errors++;
         $display("FAIL drop_count: got %0d, expected 1", drop0);
      end
      drive_meta(1'b0, ma);
      drive_meta(1'b0, mb);
      drive_meta(1'b0, mc);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus0.o_data_valid && n < 20);
      pat = 13'd1;
      for (int i = 1; i < 13; i++) begin
         @(negedge clk);
         pat = {pat[11:0], bus0.o_data_valid};
      end
      checks++;
      if (pat !== 13'b1111110111111) begin
         errors++;
         $display("FAIL back_to_back: valid pattern %b, expected 1111110111111", pat);
      end
      tick();
      wait_drain(10, "drop");
      repeat (5) tick();
      checks++;
      if (drop0 !== 32'd1 || err0 !== 1'b0) begin
         errors++;
         $display("FAIL drop_final: got drop=%0d err=%b, expected drop=1 err=0", drop0, err0);
      end
   endtask

   task automatic test_random_ready();
      logic [META_W-1:0] m;
      m = {4{$urandom}};
      send_pkt(10, m, 1'b1);
      drive_meta(1'b0, m);
      for (int i = 0; i < 300 && sb.size() != 0; i++) begin
         bus0.i_ready = 1'($urandom_range(0, 1));
         tick();
      end
      bus0.i_ready = 1'b1;
      wait_drain(5, "random_ready");
      repeat (3) tick();
   endtask

   task automatic test_orphan_meta();
      checks++;
      if (err0 !== 1'b0) begin
         errors++;
         $display("FAIL err_before_orphan: got %b, expected 0", err0);
      end
      drive_meta(1'b0, {4{$urandom}});
      repeat (3) tick();
      checks++;
      if (err0 !== 1'b1) begin
         errors++;
         $display("FAIL orphan_meta_err: got %b, expected 1", err0);
      end
   endtask

   task automatic test_reset_mid_output();
      logic [META_W-1:0] m;
      int n;
      m = {4{$urandom}};
      bus0.i_ready = 1'b0;
      send_pkt(4, m, 1'b1);
      drive_meta(1'b0, m);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus0.o_data_valid && n < 20);
      checks++;
      if (!bus0.o_data_valid) begin
         errors++;
         $display("FAIL stall_timeout: no head within 20 cycles, expected one");
      end
      repeat (3) @(negedge clk);
      #2;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      sb.delete();
      @(negedge clk);
      checks++;
      if ({bus0.o_data_valid, bus0.o_data, bus0.o_meta, drop0, err0} !== '0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got vld=%b data=%h meta=%h drop=%0d err=%b, expected all 0",
                  bus0.o_data_valid, bus0.o_data, bus0.o_meta, drop0, err0);
      end
      tick();
      rst_n        = 1'b1;
      bus0.i_ready = 1'b1;
      mon_en       = 1'b1;
      tick();
   endtask

   task automatic test_after_reset();
      logic [META_W-1:0] m;
      m = {4{$urandom}};
      drive_beat(1'b0, TAG_BODY, 4'd15, rand_data());
      drive_beat(1'b0, TAG_TAIL, 4'd3, rand_data());
      send_pkt(2, m, 1'b1);
      drive_meta(1'b0, m);
      wait_drain(20, "after_reset");
      repeat (4) tick();
      checks++;
      if (err0 !== 1'b0 || drop0 !== 32'd0) begin
         errors++;
         $display("FAIL after_reset_status: got err=%b drop=%0d, expected 0/0", err0, drop0);
      end
   endtask

   initial begin
      bus0.i_data_valid = 1'b0; bus0.i_data = '0; bus0.i_meta_valid = 1'b0; bus0.i_meta = '0;
      bus0.i_ready      = 1'b1;
      bus2.i_data_valid = 1'b0; bus2.i_data = '0; bus2.i_meta_valid = 1'b0; bus2.i_meta = '0;
      bus2.i_ready      = 1'b1;
      #1;
      test_reset();
      mon_en = 1'b1;
      test_mode0_latency();
      test_mode2_rewrite();
      test_drop_back_to_back();
      test_random_ready();
      test_orphan_meta();
      test_reset_mid_output();
      test_after_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
